// File: rtl/mbx_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : mbx_multi_channel
// Brief    : N-channel mailbox, per-channel ctrl/status and register FIFO,
//            shared write/read register ports, per-channel interrupts.
//            Optional channel flush is compiled in with MBX_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mbx_multi_channel #(
    parameter int NUM_CH = 4,
    parameter int DW     = 32,
    parameter int DEPTH  = 16
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      wr_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [1:0]                                wr_sel,
    input  logic [DW-1:0]                             wdata,
    input  logic                                      rd_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    input  logic [1:0]                                rd_sel,
    output logic [DW-1:0]                             rdata,
    output logic                                      rvalid,
    output logic [NUM_CH-1:0]                         int_flag,
    output logic                                      int_any,
    output logic [NUM_CH-1:0]                         ch_empty,
    output logic [NUM_CH-1:0]                         ch_full
);

    localparam int c_cw   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_aw   = $clog2(DEPTH);
    localparam int c_cntw = c_aw + 1;

    logic [DW-1:0] w_ctrl_rd  [NUM_CH];
    logic [DW-1:0] w_sts_rd   [NUM_CH];
    logic [DW-1:0] w_pop_data [NUM_CH];
    logic [DW-1:0] w_rd_val;
    logic          w_unused_wdata;

    assign w_unused_wdata = ^wdata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DW-1:0]     r_mem [DEPTH];
        logic [c_aw-1:0]   r_wptr, r_rptr;
        logic [c_cntw-1:0] r_count, w_count_nxt;
        logic [7:0]        r_thr, w_thr_eff;
        logic              r_int_en, r_mode, r_sts, r_pend, r_ovf, r_udf, r_flag;
        logic              w_ctrl_wr, w_data_wr, w_sts_wr, w_pop, w_flush;
        logic              w_empty, w_full, w_pop_ok, w_push_ok, w_set;

        assign w_ctrl_wr = wr_en && (wr_ch == c_cw'(i)) && (wr_sel == 2'b00);
        assign w_data_wr = wr_en && (wr_ch == c_cw'(i)) && (wr_sel == 2'b01);
        assign w_sts_wr  = wr_en && (wr_ch == c_cw'(i)) && (wr_sel == 2'b10);
        assign w_pop     = rd_en && (rd_ch == c_cw'(i)) && (rd_sel == 2'b01);

`ifdef MBX_FLUSH_EN
        assign w_flush = w_ctrl_wr && wdata[2];
`else
        assign w_flush = 1'b0;
`endif

        assign w_empty   = (r_count == '0);
        assign w_full    = (r_count == c_cntw'(DEPTH));
        assign w_pop_ok  = w_pop && !w_empty && !w_flush;
        // A pop in the same cycle frees the slot a full-FIFO push needs
        assign w_push_ok = w_data_wr && (!w_full || w_pop_ok);

        assign w_count_nxt = w_flush ? '0 :
                             r_count + c_cntw'(w_push_ok) - c_cntw'(w_pop_ok);
        assign w_thr_eff   = (r_thr == 8'd0) ? 8'd1 : r_thr;
        assign w_set       = r_mode ? (9'(w_count_nxt) >= {1'b0, w_thr_eff})
                                    : (w_count_nxt != '0);

        always_ff @(posedge clk) begin
            if (w_push_ok) r_mem[r_wptr] <= wdata;
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_count  <= '0;
                r_thr    <= '0;
                r_int_en <= 1'b0;
                r_mode   <= 1'b0;
                r_sts    <= 1'b0;
                r_pend   <= 1'b0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
                r_flag   <= 1'b0;
            end else begin
                if (w_ctrl_wr) begin
                    r_int_en <= wdata[0];
                    r_mode   <= wdata[1];
                    r_thr    <= wdata[15:8];
                end
                if (w_sts_wr) r_sts <= wdata[0];
                if (w_flush) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_push_ok) r_wptr <= r_wptr + 1'b1;
                    if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
                end
                r_count <= w_count_nxt;

                if (w_flush)                   r_pend <= 1'b0;
                else if (w_set)                r_pend <= 1'b1;
                else if (w_count_nxt == '0)    r_pend <= 1'b0;
                else if (w_sts_wr && wdata[1]) r_pend <= 1'b0;

                if (w_flush)                     r_ovf <= 1'b0;
                else if (w_data_wr && !w_push_ok) r_ovf <= 1'b1;
                else if (w_sts_wr && wdata[2])   r_ovf <= 1'b0;

                if (w_flush)                   r_udf <= 1'b0;
                else if (w_pop && w_empty)     r_udf <= 1'b1;
                else if (w_sts_wr && wdata[3]) r_udf <= 1'b0;

                r_flag <= r_pend & r_int_en & r_sts;
            end
        end

        assign w_ctrl_rd[i]  = DW'({16'd0, r_thr, 5'd0, 1'b0, r_mode, r_int_en});
        assign w_sts_rd[i]   = DW'({16'(r_count), 10'd0, w_full, w_empty,
                                    r_udf, r_ovf, r_pend, r_sts});
        assign w_pop_data[i] = w_pop_ok ? r_mem[r_rptr] : '0;
        assign ch_empty[i]   = w_empty;
        assign ch_full[i]    = w_full;
        assign int_flag[i]   = r_flag;
    end

    assign int_any = |int_flag;

    always_comb begin
        w_rd_val = '0;
        if (int'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                2'b00:   w_rd_val = w_ctrl_rd[rd_ch];
                2'b01:   w_rd_val = w_pop_data[rd_ch];
                2'b10:   w_rd_val = w_sts_rd[rd_ch];
                default: w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            rdata  <= rd_en ? w_rd_val : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mbx_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbx_multi_channel
// Brief    : Scoreboard bench for mbx_multi_channel (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbx_multi_channel;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [1:0]  wr_sel = '0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_ch = '0;
    logic [1:0]  rd_sel = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [3:0]  int_flag;
    logic        int_any;
    logic [3:0]  ch_empty;
    logic [3:0]  ch_full;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    mbx_multi_channel #(.NUM_CH(4), .DW(32), .DEPTH(16)) dut (
        .clk(clk), .rstn(rstn),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wdata(wdata),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rdata(rdata), .rvalid(rvalid),
        .int_flag(int_flag), .int_any(int_any),
        .ch_empty(ch_empty), .ch_full(ch_full)
    );

    always #5 clk = ~clk;

    // Read-response monitor
    always @(negedge clk) begin
        if (rstn === 1'b1 && rvalid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata %h, required no response", rdata);
            end else begin
                automatic logic [31:0] e  = exp_q.pop_front();
                automatic string       nm = name_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", nm, rdata, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, e);
        end
    endtask

    task automatic acc(input bit dw, input logic [1:0] wc, input logic [1:0] ws,
                       input logic [31:0] wd, input bit dr, input logic [1:0] rc,
                       input logic [1:0] rs, input logic [31:0] e, input string nm);
        wr_en = dw; wr_ch = wc; wr_sel = ws; wdata = wd;
        rd_en = dr; rd_ch = rc; rd_sel = rs;
        if (dr) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] c, input logic [1:0] s, input logic [31:0] d);
        acc(1'b1, c, s, d, 1'b0, 2'd0, 2'd0, 32'h0, "");
    endtask

    task automatic rd(input logic [1:0] c, input logic [1:0] s, input logic [31:0] e,
                      input string nm);
        acc(1'b0, 2'd0, 2'd0, 32'h0, 1'b1, c, s, e, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ch_empty", {28'd0, ch_empty}, 32'hF);
        chk("reset_ch_full",  {28'd0, ch_full},  32'h0);
        chk("reset_int_flag", {27'd0, int_any, int_flag}, 32'h0);
        chk("reset_rvalid",   {31'd0, rvalid}, 32'h0);
        chk("reset_rdata",    rdata, 32'h0);
        rstn = 1'b1;

        rd(2'd0, 2'b10, 32'h0000_0010, "ch0_status_after_reset");
        rd(2'd0, 2'b00, 32'h0000_0000, "ch0_ctrl_after_reset");
        rd(2'd0, 2'b11, 32'h0000_0000, "reserved_sel_read");

        // ch1: interrupt on not-empty
        wr(2'd1, 2'b00, 32'h1);
        wr(2'd1, 2'b10, 32'h1);
        wr(2'd1, 2'b01, 32'hA5A5_A5A5);
        idle(1);
        chk("ch1_int_flag_after_push", {28'd0, int_flag}, 32'h2);
        chk("int_any_after_push", {31'd0, int_any}, 32'h1);
        rd(2'd1, 2'b10, 32'h0001_0003, "ch1_status_one_entry");
        rd(2'd1, 2'b01, 32'hA5A5_A5A5, "ch1_pop");
        idle(1);
        chk("ch1_int_flag_after_drain", {28'd0, int_flag}, 32'h0);
        chk("ch1_empty_after_drain", {31'd0, ch_empty[1]}, 32'h1);

        // ch2: overflow then underflow
        for (int i = 0; i < 17; i++) wr(2'd2, 2'b01, 32'(i));
        chk("ch2_full", {28'd0, ch_full}, 32'h4);
        rd(2'd2, 2'b10, 32'h0010_0026, "ch2_status_full_ovf");
        for (int i = 0; i < 16; i++) rd(2'd2, 2'b01, 32'(i), "ch2_pop_order");
        rd(2'd2, 2'b01, 32'h0, "ch2_pop_empty");
        rd(2'd2, 2'b10, 32'h0000_001C, "ch2_status_udf_ovf");
        wr(2'd2, 2'b10, 32'hC);
        rd(2'd2, 2'b10, 32'h0000_0010, "ch2_status_after_w1c");

        // ch3: threshold interrupt, set beats W1C
        wr(2'd3, 2'b00, 32'h0000_0403);
        wr(2'd3, 2'b10, 32'h1);
        for (int i = 0; i < 3; i++) wr(2'd3, 2'b01, 32'h10 + 32'(i));
        idle(2);
        chk("ch3_below_threshold", {31'd0, int_flag[3]}, 32'h0);
        wr(2'd3, 2'b01, 32'h13);
        idle(1);
        chk("ch3_at_threshold", {31'd0, int_flag[3]}, 32'h1);
        wr(2'd3, 2'b10, 32'h3);
        wr(2'd3, 2'b01, 32'h14);
        rd(2'd3, 2'b10, 32'h0005_0003, "ch3_status_pend_kept");
        idle(1);
        chk("ch3_flag_kept", {31'd0, int_flag[3]}, 32'h1);

        // ch0: push+pop on a full FIFO
        for (int i = 0; i < 16; i++) wr(2'd0, 2'b01, 32'h100 + 32'(i));
        acc(1'b1, 2'd0, 2'b01, 32'h55, 1'b1, 2'd0, 2'b01, 32'h100, "ch0_full_pushpop");
        chk("ch0_still_full", {31'd0, ch_full[0]}, 32'h1);
        rd(2'd0, 2'b10, 32'h0010_0022, "ch0_status_no_ovf");
        for (int i = 1; i < 16; i++) rd(2'd0, 2'b01, 32'h100 + 32'(i), "ch0_pop_order");
        rd(2'd0, 2'b01, 32'h55, "ch0_pop_pushed_word");

        // ch0: flush
        for (int i = 0; i < 5; i++) wr(2'd0, 2'b01, 32'h200 + 32'(i));
        wr(2'd0, 2'b00, 32'h4);
`ifdef MBX_FLUSH_EN
        rd(2'd0, 2'b10, 32'h0000_0010, "ch0_status_after_flush");
        chk("ch0_empty_after_flush", {31'd0, ch_empty[0]}, 32'h1);
`else
        rd(2'd0, 2'b10, 32'h0005_0002, "ch0_status_no_flush");
        chk("ch0_not_empty_no_flush", {31'd0, ch_empty[0]}, 32'h0);
`endif
        rd(2'd0, 2'b00, 32'h0, "ch0_ctrl_bit2_reads_0");

        idle(3);
        while (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no response required %h", name_q.pop_front(), exp_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
